// File: rtl/fwft_sync_fifo_if.sv
// ---------------------------------------------------------------------------
// fwft_sync_fifo_if
//
// Purpose: bundles the producer-side and consumer-side handshake of the
// first-word-fall-through FIFO, plus its occupancy count.
//
// Signals:
//   enq_valid / enq_data / enq_ready : producer -> FIFO ready/valid channel
//   deq_valid / deq_data / deq_ready : FIFO -> consumer ready/valid channel
//   count                            : entries held (LOGDEPTH+1 bits)
//
// Modports:
//   slave  : the FIFO itself (accepts enq, presents deq)
//   master : the surrounding logic that drives enq and consumes deq
// ---------------------------------------------------------------------------
interface fwft_sync_fifo_if #(
    parameter int WIDTH    = 32,
    parameter int LOGDEPTH = 4
);
    logic                enq_valid;
    logic [WIDTH-1:0]    enq_data;
    logic                enq_ready;
    logic                deq_valid;
    logic [WIDTH-1:0]    deq_data;
    logic                deq_ready;
    logic [LOGDEPTH:0]   count;

    modport slave (
        input  enq_valid, enq_data, deq_ready,
        output enq_ready, deq_valid, deq_data, count
    );

    modport master (
        output enq_valid, enq_data, deq_ready,
        input  enq_ready, deq_valid, deq_data, count
    );
endinterface

// File: rtl/fwft_sync_fifo.sv
// ---------------------------------------------------------------------------
// fwft_sync_fifo
//
// Purpose: synchronous first-word-fall-through FIFO built around a
// dual-ported RAM with a registered (1-cycle) read. A two-stage prefetch
// pipeline (RAM read register -> output register) keeps one entry read
// ahead so a consumer holding deq_ready high drains one entry per cycle.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous, active-high reset (discards all entries)
//   flush : (only with FIFO_FLUSH_EN defined) synchronous clear of the
//           queue contents; enq_ready stays high while it is asserted
//   bus   : fwft_sync_fifo_if.slave (enq/deq handshakes and count)
//
// Configuration macro:
//   FIFO_FLUSH_EN : adds the flush input. Undefined by default.
//
// Latency: an entry enqueued into an empty FIFO at edge T is written to
// RAM at T, read into the RAM output register at T+1 and loaded into the
// output register at T+2, so it is visible in the cycle after edge T+2.
// ---------------------------------------------------------------------------
module fwft_sync_fifo #(
    parameter int WIDTH    = 32,
    parameter int LOGDEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef FIFO_FLUSH_EN
    input  logic                 flush,
`endif
    fwft_sync_fifo_if.slave      bus
);

    localparam int                CW        = LOGDEPTH + 1;
    localparam int                DEPTH     = 1 << LOGDEPTH;
    localparam logic [CW-1:0]     DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [LOGDEPTH-1:0] PTR_ONE = LOGDEPTH'(1);

    // Storage and its registered read port (no reset: contents survive rst)
    logic [WIDTH-1:0]    ram_q [DEPTH];
    logic [WIDTH-1:0]    rdata_q;

    logic [LOGDEPTH-1:0] wptr_q, wptr_d;
    logic [LOGDEPTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                s1_valid_q, s1_valid_d;    // rdata_q holds a live entry
    logic                out_valid_q, out_valid_d;  // output register holds the head
    logic [WIDTH-1:0]    out_data_q, out_data_d;

    logic                clear;
    logic                enq_ready;
    logic                enq_fire;
    logic                deq_fire;
    logic                out_load;
    logic                rd_en;
    logic [CW-1:0]       unread;

    always_comb begin
`ifdef FIFO_FLUSH_EN
        clear = rst | flush;
`else
        clear = rst;
`endif
        // Only rst (not flush) blocks the producer; count_q is a register,
        // so there is no path from enq_valid or deq_ready.
        enq_ready = !rst && (count_q != DEPTH_CNT);
        enq_fire  = bus.enq_valid && enq_ready && !clear;
        deq_fire  = out_valid_q && bus.deq_ready && !clear;

        // Entries written to RAM but not yet pulled into the pipeline. Built
        // from count_q only, so a slot is read no earlier than one edge after
        // its write.
        unread = count_q - CW'(s1_valid_q) - CW'(out_valid_q);

        // Output register refills from the RAM read register whenever it is
        // empty or being emptied this edge.
        out_load = s1_valid_q && (!out_valid_q || deq_fire) && !clear;
        // Read ahead whenever the RAM read register is free or being moved on.
        rd_en    = (unread != '0) && (!s1_valid_q || out_load) && !clear;

        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (clear) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else begin
            if (enq_fire) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (rd_en) begin
                rptr_d = rptr_q + PTR_ONE;
            end

            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            s1_valid_d = rd_en || (s1_valid_q && !out_load);

            if (out_load) begin
                out_valid_d = 1'b1;
                out_data_d  = rdata_q;
            end else if (deq_fire) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        wptr_q      <= wptr_d;
        rptr_q      <= rptr_d;
        count_q     <= count_d;
        s1_valid_q  <= s1_valid_d;
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
    end

    // RAM write port and registered read port
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            ram_q[wptr_q] <= bus.enq_data;
        end
        if (rd_en) begin
            rdata_q <= ram_q[rptr_q];
        end
    end

    assign bus.enq_ready = enq_ready;
    assign bus.deq_valid = out_valid_q;
    assign bus.deq_data  = out_data_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_fwft_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_fwft_sync_fifo
//
// Purpose: directed self-checking bench for fwft_sync_fifo (WIDTH=32,
// LOGDEPTH=4). Covers reset, fall-through latency, hold stability, full /
// drop behaviour, streaming across pointer wrap, a random run against a
// queue scoreboard, and reset (plus flush when FIFO_FLUSH_EN is defined)
// in the middle of operation. Inputs change and outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_fwft_sync_fifo;

    localparam int WIDTH    = 32;
    localparam int LOGDEPTH = 4;
    localparam int DEPTH    = 16;

    logic clk = 1'b0;
    logic rst;
`ifdef FIFO_FLUSH_EN
    logic flush;
`endif

    fwft_sync_fifo_if #(.WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH)) bus ();

    fwft_sync_fifo #(.WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef FIFO_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb [$];
    int          tx;
    int          rx;
    bit          e_fire;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push1(input logic [31:0] d);
        bus.enq_valid = 1'b1;
        bus.enq_data  = d;
        tick();
        bus.enq_valid = 1'b0;
    endtask

    // One scoreboard step at a falling edge: check, account for the
    // transfers of the coming edge, then advance.
    task automatic sb_step(input string phase);
        chk({phase, "_count"}, bus.count, sb.size());
        chk({phase, "_ready"}, bus.enq_ready, sb.size() != DEPTH);
        e_fire = bus.enq_valid && (sb.size() != DEPTH);
        if (bus.deq_valid) begin
            chk({phase, "_nonempty"}, sb.size() > 0, 1);
            if (sb.size() > 0) begin
                chk({phase, "_data"}, bus.deq_data, sb[0]);
                if (bus.deq_ready) begin
                    $display("%s deq data=%08h", phase, bus.deq_data);
                    void'(sb.pop_front());
                end
            end
        end
        if (e_fire) sb.push_back(bus.enq_data);
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        bus.enq_valid = 1'b0;
        bus.enq_data  = '0;
        bus.deq_ready = 1'b0;
`ifdef FIFO_FLUSH_EN
        flush         = 1'b0;
`endif

        // ---- reset then idle
        repeat (3) tick();
        chk("rst_count", bus.count, 0);
        chk("rst_valid", bus.deq_valid, 0);
        chk("rst_data", bus.deq_data, 0);
        chk("rst_ready_low", bus.enq_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready_high", bus.enq_ready, 1);
        @(negedge clk);

        // ---- single enqueue, fall-through latency and hold
        push1(32'hA5A5_A5A5);
        chk("ft_count", bus.count, 1);
        chk("ft_t0_valid", bus.deq_valid, 0);
        tick();
        chk("ft_t1_valid", bus.deq_valid, 0);
        tick();
        chk("ft_t2_valid", bus.deq_valid, 1);
        chk("ft_t2_data", bus.deq_data, 32'hA5A5_A5A5);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid", bus.deq_valid, 1);
            chk("hold_data", bus.deq_data, 32'hA5A5_A5A5);
        end

        // ---- simultaneous enq/deq at count==1
        bus.enq_valid = 1'b1;
        bus.enq_data  = 32'h5A5A_5A5A;
        bus.deq_ready = 1'b1;
        $display("one deq data=%08h", bus.deq_data);
        tick();
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b0;
        chk("one_count", bus.count, 1);
        chk("one_t0_valid", bus.deq_valid, 0);
        tick();
        chk("one_t1_valid", bus.deq_valid, 0);
        tick();
        chk("one_t2_valid", bus.deq_valid, 1);
        chk("one_t2_data", bus.deq_data, 32'h5A5A_5A5A);
        bus.deq_ready = 1'b1;
        $display("one deq data=%08h", bus.deq_data);
        tick();
        bus.deq_ready = 1'b0;
        chk("one_empty_count", bus.count, 0);
        chk("one_empty_valid", bus.deq_valid, 0);

        // ---- fill to capacity, drop a 17th offer, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            bus.enq_valid = 1'b1;
            bus.enq_data  = i;
            tick();
            chk("fill_count", bus.count, i + 1);
        end
        chk("full_ready", bus.enq_ready, 0);
        bus.enq_data = 32'd99;
        tick();
        bus.enq_valid = 1'b0;
        chk("full_drop_count", bus.count, DEPTH);
        bus.deq_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_valid", bus.deq_valid, 1);
            chk("drain_data", bus.deq_data, i);
            $display("drain deq data=%08h", bus.deq_data);
            tick();
        end
        bus.deq_ready = 1'b0;
        chk("drain_count", bus.count, 0);
        chk("drain_valid_end", bus.deq_valid, 0);

        // ---- streaming 40 values, both sides always active
        tx = 0;
        rx = 0;
        bus.enq_valid = 1'b1;
        bus.enq_data  = 0;
        bus.deq_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && rx < 40; cyc++) begin
            chk("stream_count", bus.count, tx - rx);
            if (rx > 0) chk("stream_nobubble", bus.deq_valid, 1);
            if (bus.deq_valid && tx < 40) chk("stream_steady", bus.count, 3);
            if (bus.deq_valid) begin
                chk("stream_data", bus.deq_data, rx);
                $display("stream deq data=%08h", bus.deq_data);
                rx++;
            end
            if (bus.enq_valid && bus.enq_ready) tx++;
            tick();
            bus.enq_valid = (tx < 40);
            bus.enq_data  = tx;
        end
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b0;
        chk("stream_received", rx, 40);
        chk("stream_end_count", bus.count, 0);

        // ---- random traffic against the scoreboard
        sb.delete();
        bus.enq_valid = 1'($urandom_range(0, 1));
        bus.enq_data  = $urandom;
        bus.deq_ready = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 2000; cyc++) begin
            sb_step("rnd");
            bus.enq_valid = 1'($urandom_range(0, 1));
            bus.enq_data  = $urandom;
            bus.deq_ready = 1'($urandom_range(0, 1));
        end
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && (sb.size() > 0 || bus.deq_valid); cyc++) begin
            sb_step("rdr");
        end
        bus.deq_ready = 1'b0;
        chk("rnd_left", sb.size(), 0);
        chk("rnd_end_valid", bus.deq_valid, 0);
        chk("rnd_end_count", bus.count, 0);

        // ---- reset in the middle of operation with a coinciding dequeue
        for (int i = 0; i < 7; i++) push1(32'h100 + i);
        tick();
        tick();
        chk("mid_count", bus.count, 7);
        chk("mid_head", bus.deq_data, 32'h100);
        rst           = 1'b1;
        bus.deq_ready = 1'b1;
        tick();
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_valid", bus.deq_valid, 0);
        chk("mid_rst_data", bus.deq_data, 0);
        chk("mid_rst_ready", bus.enq_ready, 0);
        rst           = 1'b0;
        bus.deq_ready = 1'b0;
        #1;
        chk("mid_ready_back", bus.enq_ready, 1);
        @(negedge clk);
        push1(32'h1234);
        chk("post_rst_count", bus.count, 1);
        tick();
        chk("post_rst_t1_valid", bus.deq_valid, 0);
        tick();
        chk("post_rst_valid", bus.deq_valid, 1);
        chk("post_rst_data", bus.deq_data, 32'h1234);
        $display("post_rst deq data=%08h", bus.deq_data);

`ifdef FIFO_FLUSH_EN
        // ---- same scenario using flush; flush beats a coinciding enq and deq
        for (int i = 0; i < 6; i++) push1(32'h200 + i);
        tick();
        chk("fl_count", bus.count, 7);
        flush         = 1'b1;
        bus.deq_ready = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_data  = 32'hDEAD;
        #1;
        chk("fl_ready", bus.enq_ready, 1);
        tick();
        flush         = 1'b0;
        bus.deq_ready = 1'b0;
        bus.enq_valid = 1'b0;
        chk("fl_count_clr", bus.count, 0);
        chk("fl_valid_clr", bus.deq_valid, 0);
        push1(32'h5678);
        chk("post_fl_count", bus.count, 1);
        tick();
        chk("post_fl_t1_valid", bus.deq_valid, 0);
        tick();
        chk("post_fl_valid", bus.deq_valid, 1);
        chk("post_fl_data", bus.deq_data, 32'h5678);
        $display("post_fl deq data=%08h", bus.deq_data);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on the whole run
    initial begin
        #2000000;
        bad++;
        total++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwft_sync_fifo.md
Name: fwft_sync_fifo

Overview:
- Synchronous first-word-fall-through FIFO. It wraps a dual-ported synchronous-read RAM (1-cycle read latency) with pointer, count and prefetch logic.
- Presents ready/valid handshakes on both sides. The head entry is always visible on deq_data while deq_valid is high.
- Sits between a producer stage and a consumer stage in the same clock domain. It is the standard buffering element for inter-stage queues.

Parameters:
- WIDTH, 32, data width in bits.
- LOGDEPTH, 4, log2 of capacity; DEPTH = 2**LOGDEPTH entries; LOGDEPTH >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- enq_valid  input  1  producer offers enq_data.
- enq_data  input  WIDTH  write data.
- enq_ready  output  1  FIFO can accept; a transfer occurs on an edge where enq_valid && enq_ready.
- deq_valid  output  1  deq_data holds the oldest entry.
- deq_data  output  WIDTH  head entry.
- deq_ready  input  1  consumer takes the head; a transfer occurs on an edge where deq_valid && deq_ready.
- count  output  LOGDEPTH+1  number of accepted, not-yet-dequeued entries, including entries still in flight to the output.

Behaviour:
- Reset (rst high at an edge):
  - count=0, deq_valid=0, deq_data=0.
  - Read and write pointers cleared to 0.
  - RAM contents are not cleared.
  - enq_ready=0 while rst is high; enq_ready=1 from the first cycle after rst deasserts.
  - Reset mid-operation discards all entries. Any enq or deq coinciding with a reset edge is ignored.
- Capacity is exactly DEPTH entries. enq_ready = (count != DEPTH), driven from registers only; it never depends on enq_valid or deq_ready combinationally.
- deq_valid and deq_data are driven from registers only, with no combinational path from deq_ready.
- count update per edge: +1 on enq only, -1 on deq only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- Pointers are LOGDEPTH bits and wrap modulo DEPTH with no gap. Entry order is strictly preserved across wrap.
- Fall-through latency: an enqueue into an empty FIFO at edge T gives deq_valid=1 with that data in the cycle after edge T+2. No combinational enq-to-deq bypass.
- Stability: while deq_valid && !deq_ready, deq_data and deq_valid hold unchanged.
- After a dequeue at edge T with further entries present, the next entry appears in the cycle after edge T. This means:
  - prefetch keeps one entry read ahead;
  - a dequeue every cycle (deq_ready held 1) sustains full throughput with no bubbles once the first entry is visible.
- Simultaneous enq and deq:
  - Legal at any occupancy, including count==DEPTH (enq_ready=0 there, so only deq occurs).
  - At count==1 with the head visible: the head is dequeued and the new entry appears 2 cycles after its enqueue edge.
- Same-address RAM read/write does not occur for visible data: the read pointer only reads slots written at least one edge earlier.
- Enqueue attempts while full (enq_valid=1, enq_ready=0) are dropped silently. The producer must hold its data.

Optional Feature:
- Macro FIFO_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush high at an edge clears count, pointers and deq_valid exactly like rst. enq_ready stays 1 during flush.
  - flush has priority over a simultaneous enq or deq; neither transfer occurs.
  - The first enqueue after flush follows the normal 2-cycle fall-through.
- Not defined: port flush is absent; only rst clears state.

Test Plan:
- Reset then idle: rst held 3 cycles -> count=0, deq_valid=0, deq_data=0; enq_ready=1 the cycle after rst drops.
- Single enqueue of 0xA5A5A5A5 into empty FIFO at edge T, deq_ready=0 -> deq_valid=1, deq_data=0xA5A5A5A5 after edge T+2; count=1 from edge T; data held stable for 5 cycles.
- Fill with DEPTH=16 values 0..15 -> enq_ready=0 and count=16 after the 16th accept. A 17th offer of 99 is dropped. Draining yields exactly 0..15 in order; count returns to 0 and deq_valid=0.
- Streaming, both sides always valid/ready, 40 sequential values -> output order exact, pointers wrap twice, no bubbles after the first output, count constant at steady state.
- Random enq_valid/deq_ready (50% each, 2000 cycles) against a scoreboard -> no loss, duplication or reorder; count matches model every cycle.
- rst asserted at count=7 with a deq handshake on the same edge -> count=0, deq_valid=0; the next enqueue (0x1234) is first out. With FIFO_FLUSH_EN, the same check is run using flush.
